uart_tx_engine: RTL and testbench

//  Parametrised UART transmit engine: accepts one character per vld/rdy handshake and serialises it on txd.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 27 ++
 rtl/uart_tx_engine.sv | 150 +++++++++++++++
 tb/tb_uart_tx_engine.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants, used by both the TX and RX engines.
package uart_pkg;

  typedef enum logic [2:0] {NONE, EVEN, ODD, MARK, SPACE} parity_t;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int unsigned MIN_BITS   = 5;
  localparam logic        IDLE_LEVEL = 1'b1;

  // Level of the parity bit, given the XOR of all data bits sent.
  function automatic logic parity_bit(input parity_t mode, input logic data_xor);
    case (mode)
      EVEN:    return data_xor;
      ODD:     return ~data_xor;
      MARK:    return 1'b1;
      SPACE:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: loads the divisor on restart and on every tick, and
// ticks on the last clock cycle of each bit.
module uart_baud_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == DIV_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= (div == '0) ? DIV_W'(1) : div;
    end else if (cnt != '0) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: one character per vld/rdy handshake, serialised on txd
// with a per-character frame format and runtime-programmable baud divisor.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned DATA_MAX = 9,
  parameter int unsigned DIV_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vld,
  output logic                rdy,
  input  logic [DATA_MAX-1:0] data,
  input  logic [3:0]          data_bits,
  input  parity_t             parity,
  input  logic                stop2,
  input  logic [DIV_W-1:0]    baud_div,
  output logic                txd,
  output logic                busy,
  output logic                done
);

  tx_state_t           state;
  logic [DATA_MAX-1:0] shreg;
  logic [3:0]          bit_cnt;
  logic [3:0]          nbits_q;
  parity_t             par_q;
  logic                stop2_q;
  logic                stop_cnt;
  logic                par_acc;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    div_in;
  logic [3:0]          nbits_in;
  parity_t             par_in;
  logic                xfer;
  logic                tick;
  logic                last_data_xor;

  assign rdy  = (state == IDLE);
  assign busy = ~rdy;
  assign xfer = vld && rdy;
  assign done = (state == STOP) && tick && (stop_cnt == stop2_q);
  assign last_data_xor = par_acc ^ shreg[0];

  // While idle the timer follows the live divisor so the start bit is timed
  // from the value latched at the transfer edge.
  assign div_in = rdy ? baud_div : div_q;

  always_comb begin
    nbits_in = data_bits;
    if (data_bits < 4'(MIN_BITS))
      nbits_in = 4'(MIN_BITS);
    else if (data_bits > 4'(DATA_MAX))
      nbits_in = 4'(DATA_MAX);
  end

  always_comb begin
    par_in = NONE;
    case (parity)
      EVEN, ODD, MARK, SPACE: par_in = parity;
      default:                par_in = NONE;
    endcase
  end

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (xfer),
    .div     (div_in),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      txd      <= IDLE_LEVEL;
      shreg    <= '0;
      bit_cnt  <= '0;
      nbits_q  <= 4'(MIN_BITS);
      par_q    <= NONE;
      stop2_q  <= 1'b0;
      stop_cnt <= 1'b0;
      par_acc  <= 1'b0;
      div_q    <= DIV_W'(1);
    end else begin
      case (state)
        IDLE: begin
          if (vld) begin
            state    <= START;
            txd      <= 1'b0;
            shreg    <= data;
            nbits_q  <= nbits_in;
            par_q    <= par_in;
            stop2_q  <= stop2;
            div_q    <= (baud_div == '0) ? DIV_W'(1) : baud_div;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_acc  <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            txd   <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            par_acc <= last_data_xor;
            if (bit_cnt == nbits_q - 4'd1) begin
              bit_cnt <= '0;
              if (par_q != NONE) begin
                state <= PARITY;
                txd   <= parity_bit(par_q, last_data_xor);
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state <= STOP;
            txd   <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt == stop2_q) begin
              state <= IDLE;
              txd   <= IDLE_LEVEL;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          txd   <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: hand-computed frame bit patterns checked
// cycle by cycle, plus reset, clamping, handshake and back-to-back cases.
module tb_uart_tx_engine;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vld = 1'b0;
  logic        rdy;
  logic [8:0]  data = '0;
  logic [3:0]  data_bits = 4'd8;
  parity_t     parity = NONE;
  logic        stop2 = 1'b0;
  logic [15:0] baud_div = 16'd1;
  logic        txd;
  logic        busy;
  logic        done;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(.DATA_MAX(9), .DIV_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .vld       (vld),
    .rdy       (rdy),
    .data      (data),
    .data_bits (data_bits),
    .parity    (parity),
    .stop2     (stop2),
    .baud_div  (baud_div),
    .txd       (txd),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, " idle rdy"}, 32'(rdy), 32'd1);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle txd"}, 32'(txd), 32'd1);
    chk({tag, " idle done"}, 32'(done), 32'd0);
  endtask

  task automatic launch(input logic [8:0] d, input logic [3:0] nb, input parity_t p,
                        input logic s2, input logic [15:0] div);
    data = d; data_bits = nb; parity = p; stop2 = s2; baud_div = div; vld = 1'b1;
  endtask

  // exp holds the frame's bit levels in transmission order, bit 0 first.
  task automatic run_frame(input string tag, input logic [15:0] exp, input int unsigned len,
                           input int unsigned d, input bit hold, input bit scramble);
    int unsigned total;
    total = len * d;
    for (int unsigned k = 0; k < total; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) vld = 1'b0;
      chk($sformatf("%s txd c%0d", tag, k), 32'(txd), 32'(exp[k / d]));
      chk($sformatf("%s done c%0d", tag, k), 32'(done), 32'(k == total - 1));
      chk($sformatf("%s busy c%0d", tag, k), 32'(busy), 32'd1);
      if (scramble && k == 2) begin
        data = 9'h05C; data_bits = 4'd5; parity = ODD; stop2 = 1'b1; baud_div = 16'd7; vld = 1'b1;
      end
      if (scramble && k == total - 1) vld = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("reset txd", 32'(txd), 32'd1);
    chk("reset rdy", 32'(rdy), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    reset = 1'b0;

    // 8N1 0x55, D=4: 40-clk frame
    idle_check("t1");
    launch(9'h055, 4'd8, NONE, 1'b0, 16'd4);
    run_frame("t1", 16'h02AA, 10, 4, 1'b0, 1'b0);

    // 7E2 0x03, D=2: 22-clk frame
    idle_check("t2");
    launch(9'h003, 4'd7, EVEN, 1'b1, 16'd2);
    run_frame("t2", 16'h0606, 11, 2, 1'b0, 1'b0);

    // 9O1 0x1FF: nine ones, parity 0
    idle_check("t3a");
    launch(9'h1FF, 4'd9, ODD, 1'b0, 16'd1);
    run_frame("t3a", 16'h0BFE, 12, 1, 1'b0, 1'b0);

    // data_bits=12 clamps to 9
    idle_check("t3b");
    launch(9'h155, 4'd12, NONE, 1'b0, 16'd1);
    run_frame("t3b", 16'h06AA, 11, 1, 1'b0, 1'b0);

    // data_bits=3 clamps to 5, upper data bits ignored, MARK parity
    idle_check("t3c");
    launch(9'h1F6, 4'd3, MARK, 1'b0, 16'd2);
    run_frame("t3c", 16'h00EC, 8, 2, 1'b0, 1'b0);

    // Out-of-range parity encoding behaves as NONE
    idle_check("t3d");
    launch(9'h00A, 4'd5, parity_t'(3'd7), 1'b0, 16'd1);
    run_frame("t3d", 16'h0054, 7, 1, 1'b0, 1'b0);

    // SPACE parity, two stop bits
    idle_check("t3e");
    launch(9'h01F, 4'd5, SPACE, 1'b1, 16'd1);
    run_frame("t3e", 16'h01BE, 9, 1, 1'b0, 1'b0);

    // baud_div=0 acts as 1; inputs scrambled and vld raised mid-frame
    idle_check("t4");
    launch(9'h0A3, 4'd8, NONE, 1'b0, 16'd0);
    run_frame("t4", 16'h0346, 10, 1, 1'b0, 1'b1);

    // Back-to-back frames with vld held: one idle clk between frames
    idle_check("t5pre");
    launch(9'h000, 4'd8, NONE, 1'b0, 16'd2);
    run_frame("t5a", 16'h0200, 10, 2, 1'b1, 1'b0);
    idle_check("t5gap1");
    launch(9'h0FF, 4'd8, NONE, 1'b0, 16'd2);
    run_frame("t5b", 16'h03FE, 10, 2, 1'b1, 1'b0);
    idle_check("t5gap2");
    launch(9'h00F, 4'd8, NONE, 1'b0, 16'd2);
    run_frame("t5c", 16'h021E, 10, 2, 1'b0, 1'b0);

    // Reset during data bit 3 (txd low), then a clean frame
    idle_check("t6pre");
    launch(9'h055, 4'd8, NONE, 1'b0, 16'd4);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) vld = 1'b0;
    end
    chk("t6 pre-reset txd", 32'(txd), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("t6 async txd", 32'(txd), 32'd1);
    chk("t6 async rdy", 32'(rdy), 32'd1);
    chk("t6 async busy", 32'(busy), 32'd0);
    chk("t6 async done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_check("t6post");
    launch(9'h096, 4'd8, NONE, 1'b0, 16'd3);
    run_frame("t6", 16'h032C, 10, 3, 1'b0, 1'b0);
    idle_check("t6end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
